fir_controller: RTL and testbench
=================================

FIR_CONTROLLER -- requirements
Module: fir_controller

Interface
REQ-001 SHALL have parameter-free ports; sizing constants come from fir_pkg.
REQ-002 clk  in  1  single system clock, rising-edge.
REQ-003 n_rst  in  1  asynchronous, active-low reset.
REQ-004 dr  in  1  sample ready (the slave's data_ready); held high until the slave sees processed.
REQ-005 lc  in  1  load coefficients (the slave's new_coefficient_set).
REQ-006 overflow  in  1  combinational overflow flag from the datapath for the op issued this cycle.
REQ-007 modwait  out  1  filter busy.
REQ-008 err  out  1  filter error status.
REQ-009 processed  out  1  one-cycle pulse: sample consumed; the slave clears dr on the next edge.
REQ-010 clear_new_coefficient  out  1  one-cycle pulse ending a coefficient load.
REQ-011 coefficient_num  out  2  coefficient index requested from the slave.
REQ-012 cnt_up  out  1  one-cycle sample-count pulse.
REQ-013 op  out  3  datapath op: NOP=0, COPY=1, LOAD1=2 (sample_data), LOAD2=3 (fir_coefficient), ADD=4, SUB=5, MUL=6.
REQ-014 src1, src2, dest  out  4 each  datapath register indices.

Function
REQ-015 Register map: R0 accumulator; R1..R4 sample history (R1 newest); R5 new sample; R6..R9 coefficients F0..F3; R10 product.
REQ-016 All outputs SHALL be Moore decodes of the state register. Default values are op=NOP, indices=0, coefficient_num=0, and all pulses=0.
REQ-017 States: IDLE, LOAD_C0..LOAD_C3, CLR_LC, STORE, ZERO, SORT1..SORT4, MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4, DONE, ABORT, EIDLE.
REQ-018 IDLE: if lc=1, go to LOAD_C0. Else if dr=1, go to STORE. Else stay. lc has priority over dr.
REQ-019 LOAD_Ck (k=0..3): op=LOAD2, dest=R(6+k), coefficient_num=k; advance to the next state; LOAD_C3 goes to CLR_LC.
REQ-020 CLR_LC: clear_new_coefficient=1; go to IDLE.
REQ-021 STORE: op=LOAD1, dest=R5. If dr=1, go to ZERO. If dr=0, go to EIDLE.
REQ-022 ZERO: SUB R0=R0-R0; cnt_up=1.
REQ-023 SORT1..SORT4: COPY R4<-R3, R3<-R2, R2<-R1, R1<-R5, in that order.
REQ-024 MUL1/ADD1: R10=R1*R6, then R0=R0+R10. MUL2/SUB2: R10=R2*R7, then R0=R0-R10.
REQ-025 MUL3/ADD3: R10=R3*R8, then R0=R0+R10. MUL4/SUB4: R10=R4*R9, then R0=R0-R10.
REQ-026 overflow SHALL be sampled only in ADD1, SUB2, ADD3 and SUB4. When overflow=1 in one of those states, go to ABORT. It SHALL be ignored in every other state.
REQ-027 SUB4 without overflow goes to DONE. In DONE, processed=1; go to IDLE unconditionally, which ignores the stale dr.
REQ-028 ABORT: processed=1, err=1; go to EIDLE unconditionally.
REQ-029 EIDLE: err=1. If dr=1, go to STORE. Otherwise stay; lc is ignored. err returns to 0 on leaving EIDLE.
REQ-030 modwait SHALL be 1 in every state except IDLE, EIDLE, DONE and ABORT.
REQ-031 Latency: dr sampled in IDLE produces processed 15 cycles later; the coefficient load takes 5 busy cycles.
REQ-032 dr asserted during a load or sample sequence SHALL NOT alter that sequence.

Reset
REQ-033 n_rst=0 SHALL force IDLE immediately, independent of clk, so all outputs take their default values.
REQ-034 Reset mid-sequence SHALL abandon the sequence; a pending lc still set by the slave restarts the load at LOAD_C0.

Structure
REQ-035 fir_pkg SHALL hold the state enum, the op encoding and the register-index constants R0..R10.
REQ-036 A single sub-module, fir_ctrl_decode, SHALL be the combinational state-to-outputs decoder. Next-state logic and the state flop SHALL stay in fir_controller.

Verification
REQ-037 Reset then lc=1 -> coefficient_num 0,1,2,3 on LOAD2 to dests 6,7,8,9; clear_new_coefficient pulse in cycle 5; modwait high for 5 cycles.
REQ-038 dr=1 in IDLE with overflow=0 -> exact op/src/dest sequence of REQ-021..025; processed in cycle 15; err=0.
REQ-039 overflow=1 forced during SUB2 -> ABORT with processed and err=1, then EIDLE with err held; the next dr recovers to STORE and err drops.
REQ-040 dr pulsed high for 1 cycle only -> STORE sees dr=0 -> EIDLE with err=1 and no processed pulse.
REQ-041 lc=1 and dr=1 together in IDLE -> coefficient load first, then sample processing.
REQ-042 n_rst asserted in MUL3 -> immediate IDLE, op=NOP, modwait=0; after release, dr=1 restarts cleanly at STORE.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types for the FIR sequencing controller: state encoding, datapath op codes,
// register-file indices and the decoded control bundle.
package fir_pkg;

    typedef enum logic [4:0] {
        IDLE, LOAD_C0, LOAD_C1, LOAD_C2, LOAD_C3, CLR_LC,
        STORE, ZERO, SORT1, SORT2, SORT3, SORT4,
        MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4,
        DONE, ABORT, EIDLE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_COPY  = 3'd1,
        OP_LOAD1 = 3'd2,
        OP_LOAD2 = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_MUL   = 3'd6
    } op_t;

    localparam logic [3:0] R0  = 4'd0;
    localparam logic [3:0] R1  = 4'd1;
    localparam logic [3:0] R2  = 4'd2;
    localparam logic [3:0] R3  = 4'd3;
    localparam logic [3:0] R4  = 4'd4;
    localparam logic [3:0] R5  = 4'd5;
    localparam logic [3:0] R6  = 4'd6;
    localparam logic [3:0] R7  = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;

    typedef struct packed {
        op_t        op;
        logic [3:0] src1;
        logic [3:0] src2;
        logic [3:0] dest;
        logic [1:0] coefficient_num;
        logic       modwait;
        logic       err;
        logic       processed;
        logic       clear_new_coefficient;
        logic       cnt_up;
    } ctrl_t;

endpackage

// File: rtl/fir_ctrl_decode.sv
// Combinational Moore decode of controller state into datapath/handshake controls.
// Zero latency; no flow control of its own.
module fir_ctrl_decode
    import fir_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    function automatic ctrl_t alu(input op_t o, input logic [3:0] s1,
                                  input logic [3:0] s2, input logic [3:0] d);
        ctrl_t c;
        c      = '0;
        c.op   = o;
        c.src1 = s1;
        c.src2 = s2;
        c.dest = d;
        return c;
    endfunction

    always_comb begin
        ctrl = '0;
        case (state)
            LOAD_C0: begin ctrl = alu(OP_LOAD2, R0, R0, R6); ctrl.coefficient_num = 2'd0; end
            LOAD_C1: begin ctrl = alu(OP_LOAD2, R0, R0, R7); ctrl.coefficient_num = 2'd1; end
            LOAD_C2: begin ctrl = alu(OP_LOAD2, R0, R0, R8); ctrl.coefficient_num = 2'd2; end
            LOAD_C3: begin ctrl = alu(OP_LOAD2, R0, R0, R9); ctrl.coefficient_num = 2'd3; end
            CLR_LC:  ctrl.clear_new_coefficient = 1'b1;
            STORE:   ctrl = alu(OP_LOAD1, R0, R0, R5);
            ZERO:    begin ctrl = alu(OP_SUB, R0, R0, R0); ctrl.cnt_up = 1'b1; end
            // Shift the sample history oldest-first so nothing is overwritten early.
            SORT1:   ctrl = alu(OP_COPY, R3, R0, R4);
            SORT2:   ctrl = alu(OP_COPY, R2, R0, R3);
            SORT3:   ctrl = alu(OP_COPY, R1, R0, R2);
            SORT4:   ctrl = alu(OP_COPY, R5, R0, R1);
            MUL1:    ctrl = alu(OP_MUL, R1, R6, R10);
            ADD1:    ctrl = alu(OP_ADD, R0, R10, R0);
            MUL2:    ctrl = alu(OP_MUL, R2, R7, R10);
            SUB2:    ctrl = alu(OP_SUB, R0, R10, R0);
            MUL3:    ctrl = alu(OP_MUL, R3, R8, R10);
            ADD3:    ctrl = alu(OP_ADD, R0, R10, R0);
            MUL4:    ctrl = alu(OP_MUL, R4, R9, R10);
            SUB4:    ctrl = alu(OP_SUB, R0, R10, R0);
            DONE:    ctrl.processed = 1'b1;
            ABORT:   begin ctrl.processed = 1'b1; ctrl.err = 1'b1; end
            EIDLE:   ctrl.err = 1'b1;
            default: ;
        endcase
        ctrl.modwait = !(state inside {IDLE, EIDLE, DONE, ABORT});
    end

endmodule

// File: rtl/fir_controller.sv
// FIR sequencing controller: coefficient load (5 busy cycles) and 4-tap sample pass
// (processed 15 cycles after dr is seen in IDLE); overflow aborts the pass into an error idle.
module fir_controller
    import fir_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dr,
    input  logic       lc,
    input  logic       overflow,
    output logic       modwait,
    output logic       err,
    output logic       processed,
    output logic       clear_new_coefficient,
    output logic [1:0] coefficient_num,
    output logic       cnt_up,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest
);

    state_t state;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (lc) state <= LOAD_C0; else if (dr) state <= STORE;
                LOAD_C0: state <= LOAD_C1;
                LOAD_C1: state <= LOAD_C2;
                LOAD_C2: state <= LOAD_C3;
                LOAD_C3: state <= CLR_LC;
                CLR_LC:  state <= IDLE;
                STORE:   state <= dr ? ZERO : EIDLE;
                ZERO:    state <= SORT1;
                SORT1:   state <= SORT2;
                SORT2:   state <= SORT3;
                SORT3:   state <= SORT4;
                SORT4:   state <= MUL1;
                MUL1:    state <= ADD1;
                // Overflow only matters on the accumulate steps; MULs never abort.
                ADD1:    state <= overflow ? ABORT : MUL2;
                MUL2:    state <= SUB2;
                SUB2:    state <= overflow ? ABORT : MUL3;
                MUL3:    state <= ADD3;
                ADD3:    state <= overflow ? ABORT : MUL4;
                MUL4:    state <= SUB4;
                SUB4:    state <= overflow ? ABORT : DONE;
                DONE:    state <= IDLE;
                ABORT:   state <= EIDLE;
                EIDLE:   if (dr) state <= STORE;
                default: state <= IDLE;
            endcase
        end
    end

    fir_ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    assign op                    = ctrl.op;
    assign src1                  = ctrl.src1;
    assign src2                  = ctrl.src2;
    assign dest                  = ctrl.dest;
    assign coefficient_num       = ctrl.coefficient_num;
    assign modwait               = ctrl.modwait;
    assign err                   = ctrl.err;
    assign processed             = ctrl.processed;
    assign clear_new_coefficient = ctrl.clear_new_coefficient;
    assign cnt_up                = ctrl.cnt_up;

endmodule

// File: tb/tb_fir_controller.sv
// Directed bench for fir_controller: vector table of per-cycle inputs and expected
// Moore outputs, plus hand-written asynchronous reset sequences.
module tb_fir_controller;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       dr = 1'b0;
    logic       lc = 1'b0;
    logic       overflow = 1'b0;
    logic       modwait, err, processed, clear_new_coefficient, cnt_up;
    logic [1:0] coefficient_num;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;

    fir_controller dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .dr                    (dr),
        .lc                    (lc),
        .overflow              (overflow),
        .modwait               (modwait),
        .err                   (err),
        .processed             (processed),
        .clear_new_coefficient (clear_new_coefficient),
        .coefficient_num       (coefficient_num),
        .cnt_up                (cnt_up),
        .op                    (op),
        .src1                  (src1),
        .src2                  (src2),
        .dest                  (dest)
    );

    always #5 clk = ~clk;

    // {op, src1, src2, dest, coefficient_num, modwait, err, processed, clear, cnt_up}
    logic [21:0] act;
    assign act = {op, src1, src2, dest, coefficient_num,
                  modwait, err, processed, clear_new_coefficient, cnt_up};

    typedef struct {
        string       name;
        logic        dr;
        logic        lc;
        logic        ov;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   passed = 0;
    int   total  = 0;

    function automatic logic [21:0] ex(input logic [2:0] o, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic [3:0] d,
                                       input logic [1:0] cn, input logic mw, input logic er,
                                       input logic pr, input logic cl, input logic cu);
        return {o, s1, s2, d, cn, mw, er, pr, cl, cu};
    endfunction

    task automatic chk(input string name, input logic [21:0] got, input logic [21:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h (op/s1/s2/d/cn/mw/err/proc/clr/cnt)",
                      name, got, want);
    endtask

    task automatic push(input string nm, input logic d, input logic l, input logic o,
                        input logic [21:0] e);
        vec_t v;
        v.name = nm; v.dr = d; v.lc = l; v.ov = o; v.exp = e;
        tbl.push_back(v);
    endtask

    // IDLE with lc raised, four coefficient loads, clear pulse, back to IDLE.
    task automatic push_load(input logic d);
        push("idle_lc", d, 1, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            push($sformatf("load_c%0d", k), d, 1, 0, ex(3, 0, 0, 4'(6 + k), 2'(k), 1, 0, 0, 0, 0));
        push("clr_lc", d, 0, 0, ex(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    endtask

    // From STORE to DONE, or to ABORT when overflow hits accumulate step ov_at (1..4).
    task automatic push_sample(input int ov_at);
        push("store", 1, 0, 0, ex(2, 0, 0, 5, 0, 1, 0, 0, 0, 0));
        push("zero",  1, 0, 1, ex(5, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        push("sort1", 1, 0, 1, ex(1, 3, 0, 4, 0, 1, 0, 0, 0, 0));
        push("sort2", 1, 0, 0, ex(1, 2, 0, 3, 0, 1, 0, 0, 0, 0));
        push("sort3", 1, 0, 0, ex(1, 1, 0, 2, 0, 1, 0, 0, 0, 0));
        push("sort4", 1, 0, 0, ex(1, 5, 0, 1, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("mul%0d", k), 1, 0, 1, ex(6, 4'(k), 4'(5 + k), 10, 0, 1, 0, 0, 0, 0));
            push($sformatf("acc%0d", k), 1, 0, (ov_at == k),
                 ex((k % 2 == 1) ? 3'd4 : 3'd5, 0, 10, 0, 0, 1, 0, 0, 0, 0));
            if (ov_at == k) begin
                push("abort", 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
                return;
            end
        end
        push("done", 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    endtask

    initial begin
        // Coefficient load alone, then lc and dr together (load wins, sample follows).
        push_load(0);
        push("idle", 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_load(1);
        push("idle_dr", 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_sample(0);
        push("idle_dr", 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_sample(2);
        push("eidle_lc", 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int a = 1; a <= 4; a++) begin
            if (a == 2) continue;
            push("eidle_dr", 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            push_sample(a);
        end
        push("eidle_dr", 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        push_sample(0);
        // One-cycle dr pulse: STORE sees dr low and falls into the error idle.
        push("idle_pulse", 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("store_nodr", 0, 0, 0, ex(2, 0, 0, 5, 0, 1, 0, 0, 0, 0));
        push("eidle_hold", 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        push("eidle_hold", 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        #12;
        chk("reset_state", act, '0);
        #1 n_rst = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            chk($sformatf("%s[%0d]", tbl[i].name, i), act, tbl[i].exp);
            dr = tbl[i].dr;
            lc = tbl[i].lc;
            overflow = tbl[i].ov;
        end

        // Asynchronous reset out of EIDLE, then a sample run reset during MUL3.
        n_rst = 1'b0;
        #1 chk("rst_async_eidle", act, '0);
        dr = 1'b1; lc = 1'b0; overflow = 1'b0;
        #2 n_rst = 1'b1;
        repeat (11) @(negedge clk);
        chk("mul3_before_rst", act, ex(6, 3, 8, 10, 0, 1, 0, 0, 0, 0));
        #2 n_rst = 1'b0;
        #1 chk("rst_in_mul3", act, '0);
        @(negedge clk);
        chk("rst_held_idle", act, '0);
        #1 n_rst = 1'b1;
        @(negedge clk);
        chk("restart_store", act, ex(2, 0, 0, 5, 0, 1, 0, 0, 0, 0));

        // Reset mid-load with lc still pending restarts at LOAD_C0.
        n_rst = 1'b0;
        #1 dr = 1'b0; lc = 1'b1;
        #1 n_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("load_c2_before_rst", act, ex(3, 0, 0, 8, 2, 1, 0, 0, 0, 0));
        #2 n_rst = 1'b0;
        #1 chk("rst_in_load", act, '0);
        #1 n_rst = 1'b1;
        @(negedge clk);
        chk("reload_c0", act, ex(3, 0, 0, 6, 0, 1, 0, 0, 0, 0));
        lc = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
